// File: rtl/fft_64_in_packer_if.sv
// Stream bundle between a serial sample source, the frame packer and the
// FFT input port. The packer sits on the slave side: it consumes the
// sample handshake and drives the 4-lane beat bus.
interface fft_64_in_packer_if #(
    parameter int DATA_W = 16
);
    // Serial sample handshake
    logic              s_valid;
    logic              s_ready;
    logic              s_last;
    logic [DATA_W-1:0] s_re;
    logic [DATA_W-1:0] s_im;

    // Beat bus toward the FFT: lanes a..d carry samples 4k..4k+3
    logic [DATA_W-1:0] x_a_out;
    logic [DATA_W-1:0] y_a_out;
    logic [DATA_W-1:0] x_b_out;
    logic [DATA_W-1:0] y_b_out;
    logic [DATA_W-1:0] x_c_out;
    logic [DATA_W-1:0] y_c_out;
    logic [DATA_W-1:0] x_d_out;
    logic [DATA_W-1:0] y_d_out;
    logic              ctrl_out;

    // Source / observer side
    modport master (
        output s_valid, s_last, s_re, s_im,
        input  s_ready,
        input  x_a_out, y_a_out, x_b_out, y_b_out,
        input  x_c_out, y_c_out, x_d_out, y_d_out,
        input  ctrl_out
    );

    // Packer side
    modport slave (
        input  s_valid, s_last, s_re, s_im,
        output s_ready,
        output x_a_out, y_a_out, x_b_out, y_b_out,
        output x_c_out, y_c_out, x_d_out, y_d_out,
        output ctrl_out
    );
endinterface

// File: rtl/fft_64_in_packer.sv
// fft_64_in_packer: collects a serial stream of complex samples into a
// ping-pong pair of N-entry banks and replays each closed bank as N/LANES
// contiguous beats of LANES samples, natural order, beat 0 flagged on
// ctrl_out. Short frames (s_last) are zero-padded on replay by masking
// against the bank's fill count rather than by clearing storage.
module fft_64_in_packer #(
    parameter int DATA_W = 16,
    parameter int N      = 64,
    parameter int LANES  = 4
) (
    input  logic              clk,
    input  logic              rst_in,
    fft_64_in_packer_if.slave bus
);

    localparam int IDX_W  = $clog2(N);
    localparam int CNT_W  = IDX_W + 1;
    localparam int BEATS  = N / LANES;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int LANE_W = $clog2(LANES);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } rd_state_t;

    // ------------------------------------------------------------------
    // Storage: bank b occupies addresses {b, idx}
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_re [0:2*N-1];
    logic [DATA_W-1:0] mem_im [0:2*N-1];

    // ------------------------------------------------------------------
    // Write-side state
    // ------------------------------------------------------------------
    logic             ready_en_q;
    logic [IDX_W-1:0] wr_idx_q,  wr_idx_d;
    logic             wr_bank_q, wr_bank_d;
    logic [1:0]       full_q,    full_d;
    logic [CNT_W-1:0] fill_q [2];
    logic [CNT_W-1:0] fill_d [2];

    logic s_ready_w;
    logic accept_w;
    logic close_w;

    // ------------------------------------------------------------------
    // Read-side state
    // ------------------------------------------------------------------
    rd_state_t         state_q,   state_d;
    logic [BEAT_W-1:0] beat_q,    beat_d;
    logic              rd_bank_q, rd_bank_d;
    logic              free_w;
    logic [CNT_W-1:0]  rd_fill;
    logic              ctrl_q,    ctrl_d;

    logic [DATA_W-1:0] lane_re [LANES];
    logic [DATA_W-1:0] lane_im [LANES];

    // The ready qualifier holds s_ready low through reset and for the
    // reset edge itself; after that only a still-full write bank blocks.
    assign s_ready_w = ready_en_q & ~full_q[wr_bank_q];
    assign accept_w  = bus.s_valid & s_ready_w;
    assign close_w   = accept_w & (bus.s_last | (wr_idx_q == LAST_IDX));

    // The last beat of a frame releases its bank on the same edge.
    assign free_w  = (state_q == S_RUN) && (beat_q == LAST_BEAT);
    assign rd_fill = fill_q[rd_bank_q];

    // Sample storage write; contents need no reset because fill counts
    // decide what is ever replayed.
    always_ff @(posedge clk) begin
        if (accept_w) begin
            mem_re[{wr_bank_q, wr_idx_q}] <= bus.s_re;
            mem_im[{wr_bank_q, wr_idx_q}] <= bus.s_im;
        end
    end

    // Write index / bank toggling and full-flag bookkeeping. The read side
    // only ever clears the bank it is draining and the write side only sets
    // the bank it is filling, so the two never collide on one flag.
    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        full_d    = full_q;
        fill_d    = fill_q;

        if (free_w) begin
            full_d[rd_bank_q] = 1'b0;
        end

        if (accept_w) begin
            if (close_w) begin
                full_d[wr_bank_q] = 1'b1;
                fill_d[wr_bank_q] = CNT_W'(wr_idx_q) + CNT_W'(1);
                wr_idx_d          = '0;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
    end

    // Write-side registers; reset discards any partial or pending frame.
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            ready_en_q <= 1'b0;
            wr_idx_q   <= '0;
            wr_bank_q  <= 1'b0;
            full_q     <= '0;
            fill_q[0]  <= '0;
            fill_q[1]  <= '0;
        end else begin
            ready_en_q <= 1'b1;
            wr_idx_q   <= wr_idx_d;
            wr_bank_q  <= wr_bank_d;
            full_q     <= full_d;
            fill_q[0]  <= fill_d[0];
            fill_q[1]  <= fill_d[1];
        end
    end

    // Read FSM next state: start on a full bank, walk all beats without
    // stalling, then chain straight into the other bank if it is ready.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        rd_bank_d = rd_bank_q;

        case (state_q)
            S_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = S_RUN;
                    beat_d  = '0;
                end
            end
            S_RUN: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) begin
                    beat_d    = '0;
                    rd_bank_d = ~rd_bank_q;
                    state_d   = full_q[~rd_bank_q] ? S_RUN : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            rd_bank_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    assign ctrl_d = (state_q == S_RUN) && (beat_q == '0);

    // Frame-start marker register.
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            ctrl_q <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    // One output lane per generate iteration: lane gi of beat k reads
    // sample LANES*k+gi, forced to zero past the fill count or when idle.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [IDX_W-1:0]  idx;
        logic              in_frame;
        logic [DATA_W-1:0] re_d, im_d;
        logic [DATA_W-1:0] re_q, im_q;

        assign idx      = {beat_q, LANE_W'(gi)};
        assign in_frame = (state_q == S_RUN) && ({1'b0, idx} < rd_fill);

        // Select stored sample or padding zero for this lane.
        always_comb begin
            re_d = '0;
            im_d = '0;
            if (in_frame) begin
                re_d = mem_re[{rd_bank_q, idx}];
                im_d = mem_im[{rd_bank_q, idx}];
            end
        end

        // Lane output register.
        always_ff @(posedge clk) begin
            if (!rst_in) begin
                re_q <= '0;
                im_q <= '0;
            end else begin
                re_q <= re_d;
                im_q <= im_d;
            end
        end

        assign lane_re[gi] = re_q;
        assign lane_im[gi] = im_q;
    end

    assign bus.s_ready  = s_ready_w;
    assign bus.ctrl_out = ctrl_q;
    assign bus.x_a_out  = lane_re[0];
    assign bus.y_a_out  = lane_im[0];
    assign bus.x_b_out  = lane_re[1];
    assign bus.y_b_out  = lane_im[1];
    assign bus.x_c_out  = lane_re[2];
    assign bus.y_c_out  = lane_im[2];
    assign bus.x_d_out  = lane_re[3];
    assign bus.y_d_out  = lane_im[3];

endmodule

// File: doc/fft_64_in_packer.md
Name: fft_64_in_packer

Overview:
- Upstream feeder for fft_64_wrapper.
- Accepts a serial stream of complex samples, one per handshake, and assembles each 64-sample frame in a ping-pong buffer.
- Replays each frame as 16 contiguous beats of 4 complex lanes in natural order, with ctrl_out marking beat 0, matching the FFT input contract.

Parameters:
- DATA_W, 16, width of each real/imag component (two's complement).
- N, 64, samples per frame.
- LANES, 4, samples per output beat; beats per frame = N/LANES = 16.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_in  in  1  reset; synchronous, active-low.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample this cycle.
- s_last  in  1  marks last sample of a short frame; remaining slots are zero-padded.
- s_re  in  DATA_W  sample real part.
- s_im  in  DATA_W  sample imaginary part.
- x_a_out, y_a_out  out  DATA_W  lane a re/im: sample 4k of beat k.
- x_b_out, y_b_out  out  DATA_W  lane b re/im: sample 4k+1.
- x_c_out, y_c_out  out  DATA_W  lane c re/im: sample 4k+2.
- x_d_out, y_d_out  out  DATA_W  lane d re/im: sample 4k+3.
- ctrl_out  out  1  high only on beat 0 of each frame; drives fft ctrl_in.

Behaviour:
- Reset (rst_in=0 at an edge):
  - Clears write index, both bank-full flags, bank fill counts, read beat counter and read FSM.
  - All data outputs become 0, ctrl_out 0, s_ready 0.
  - s_ready goes to 1 at the first edge with rst_in=1.
  - Any partial or in-flight frame is discarded, including reset during replay.
- Storage: two banks of N complex entries, each with a full flag and a 7-bit fill count.
- Write side:
  - An accept is s_valid & s_ready at an edge; it writes the sample to the current write bank at the write index, then increments the index.
  - A bank closes on an accept at index N-1, or on an accept with s_last=1 at any index. On close: full flag set, fill count = index+1, index reset to 0, write bank toggles.
  - s_ready = 0 while the current write bank is still full (not yet drained); otherwise 1.
  - s_valid gaps are allowed anywhere; data is held until the next accept.
- Read FSM states:
  - IDLE: outputs 0, ctrl_out 0. If the read bank is full at edge t, go to RUN and register beat 0 at edge t+1.
  - RUN: at each edge, register beat k (k = 0..15), with ctrl_out = (k==0).
    - Lane sample index i = 4k+lane.
    - A lane outputs the stored value if i < fill count, else 0 (re and im).
  - After beat 15 is registered, clear that bank's full flag and toggle the read bank. If the other bank is already full, beat 0 of the next frame is registered on the very next edge (no gap); else return to IDLE.
- Output timing and content:
  - Beats of one frame are always on 16 consecutive cycles, never stalled; the FFT has no backpressure.
  - Latency: last accepted sample at edge t leads to ctrl_out/beat 0 at edge t+2 (one edge to set the full flag, one to register the beat).
  - Outputs are registered. No arithmetic or rescaling: values pass through bit-exact.
- Simultaneous events:
  - Closing a bank on the same edge the read side frees the other bank is legal; both flags update independently.
  - Write and read never touch the same bank at the same time.
- Throughput: at 1 sample/cycle input, the output duty is 16 of 64 cycles and s_ready stays 1 continuously.
- s_last on an empty bank: an accept at index 0 with s_last gives fill count 1; the frame still emits 16 beats.

Test Plan:
- Impulse: 64 accepts, s_re=1 at index 0, all else 0. Required: 16 beats; beat 0 has ctrl_out=1 and x_a_out=1; every other output and beat is 0; ctrl_out low on beats 1..15.
- Ramp: s_re=i, s_im=-i (0xFFFF.. two's complement), i=0..63. Required: beat k gives x_a..x_d = 4k..4k+3 and y_* = -(4k..4k+3); beat 15 gives x_d_out=63, y_d_out=0xFFC1.
- Back-to-back: 3 frames streamed with s_valid=1 continuously. Required: s_ready never drops; ctrl_out pulses exactly 64 cycles apart; the first pulse is 2 edges after the 64th accept.
- Short frame: samples 1..10 with s_last on the 10th. Required: beat 0 = 1,2,3,4; beat 1 = 5,6,7,8; beat 2 = 9,10,0,0; beats 3..15 = 0. The next frame's first sample lands in lane a of its beat 0.
- Sparse input: the ramp sent with s_valid every 3rd cycle. Required: output identical to the ramp case, with 16 contiguous beats.
- Reset mid-replay: rst_in=0 for 1 edge while beat 7 is on the outputs. Required: all outputs and ctrl_out are 0 at the next edge and no further beats appear; a fresh impulse frame afterwards reproduces the impulse result.
